// File: rtl/flags_context_stack_if.sv
// Bundles the flags-register control inputs and status outputs between the
// control/ALU side (master) and the flags context stack (slave).
interface flags_context_stack_if #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flags_reg_write_enable;
  logic [FLAG_W-1:0] flags_mask;
  logic [FLAG_W-1:0] d;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [FLAG_W-1:0] q;
  logic [CNT_W-1:0]  depth;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output flags_reg_write_enable, flags_mask, d, push, pop, err_clr,
    input  q, depth, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  flags_reg_write_enable, flags_mask, d, push, pop, err_clr,
    output q, depth, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/flags_context_stack.sv
// Flags register with per-bit masked write and a LIFO save/restore stack;
// overflow/underflow are recorded in sticky error flags cleared by err_clr.
module flags_context_stack #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  flags_context_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] stack_mem [DEPTH];

  logic [FLAG_W-1:0] q_reg, q_next;
  logic [CNT_W-1:0]  depth_reg, depth_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  logic [FLAG_W-1:0] base;
  logic [FLAG_W-1:0] mask_eff;
  logic              full, empty;
  logic              push_ok, pop_ok, ovf_set, unf_set;
  logic [CNT_W-1:0]  top_cnt;
  logic [AW-1:0]     wr_addr, rd_addr;

  assign full  = (depth_reg == CNT_W'(DEPTH));
  assign empty = (depth_reg == '0);

  // A simultaneous push and pop cancels out: no stack movement, no error.
  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign ovf_set = bus.push & ~bus.pop & full;
  assign unf_set = bus.pop & ~bus.push & empty;

  assign top_cnt = depth_reg - CNT_W'(1);
  assign wr_addr = depth_reg[AW-1:0];
  assign rd_addr = top_cnt[AW-1:0];

  assign base     = pop_ok ? stack_mem[rd_addr] : q_reg;
  assign mask_eff = bus.flags_reg_write_enable ? bus.flags_mask : '0;

  generate
    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_merge
      assign q_next[gi] = mask_eff[gi] ? bus.d[gi] : base[gi];
    end
  endgenerate

  always_comb begin
    depth_next = depth_reg;
    if (push_ok) begin
      depth_next = depth_reg + CNT_W'(1);
    end else if (pop_ok) begin
      depth_next = top_cnt;
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  assign ovf_next = (ovf_reg & ~bus.err_clr) | ovf_set;
  assign unf_next = (unf_reg & ~bus.err_clr) | unf_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      q_reg     <= q_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Storage is deliberately unreset; the saved value is q before this cycle's write.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_mem[wr_addr] <= q_reg;
    end
  end

  assign bus.q       = q_reg;
  assign bus.depth   = depth_reg;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.ovf_err = ovf_reg;
  assign bus.unf_err = unf_reg;
endmodule

// File: tb/tb_flags_context_stack.sv
// Directed scenarios plus randomized traffic, checked against a queue-based model.
module tb_flags_context_stack;
  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flags_context_stack_if #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) bus ();

  flags_context_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [FLAG_W-1:0] m_stack [$];
  logic [FLAG_W-1:0] m_q;
  logic              m_ovf, m_unf;

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic apply(input logic r, input logic we, input logic [FLAG_W-1:0] mask,
                       input logic [FLAG_W-1:0] dd, input logic pu, input logic po,
                       input logic clr);
    logic [FLAG_W-1:0] b, m;
    logic so, su;
    rst = r;
    bus.flags_reg_write_enable = we;
    bus.flags_mask = mask;
    bus.d = dd;
    bus.push = pu;
    bus.pop = po;
    bus.err_clr = clr;
    if (r) begin
      m_stack.delete();
      m_q = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      b = m_q;
      so = 1'b0;
      su = 1'b0;
      if (pu && !po) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_q);
        else so = 1'b1;
      end
      if (po && !pu) begin
        if (m_stack.size() > 0) b = m_stack.pop_back();
        else su = 1'b1;
      end
      m = we ? mask : '0;
      m_q = (b & ~m) | (dd & m);
      m_ovf = (m_ovf && !clr) || so;
      m_unf = (m_unf && !clr) || su;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 4'hF, 4'hF, 1, 0, 0);
    apply(1, 1, 4'hF, 4'hF, 1, 0, 0);
    vectors++; if (bus.q !== 4'b0000) begin miscompares++; $display("FAIL reset_q got=%b exp=0000", bus.q); end
    vectors++; if (bus.depth !== CNT_W'(0)) begin miscompares++; $display("FAIL reset_depth got=%0d exp=0", bus.depth); end
    vectors++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_empty_full got=%b%b exp=10", bus.empty, bus.full); end
    vectors++; if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b%b exp=00", bus.ovf_err, bus.unf_err); end
    $display("reset: q=%b depth=%0d empty=%b", bus.q, bus.depth, bus.empty);
  endtask

  task automatic test_masked_write();
    apply(0, 1, 4'b0101, 4'b1111, 0, 0, 0);
    vectors++; if (bus.q !== 4'b0101) begin miscompares++; $display("FAIL mask_write1 got=%b exp=0101", bus.q); end
    apply(0, 1, 4'b0001, 4'b0000, 0, 0, 0);
    vectors++; if (bus.q !== 4'b0100) begin miscompares++; $display("FAIL mask_write2 got=%b exp=0100", bus.q); end
    apply(0, 0, 4'b1111, 4'b1011, 0, 0, 0);
    vectors++; if (bus.q !== 4'b0100) begin miscompares++; $display("FAIL write_disabled got=%b exp=0100", bus.q); end
    $display("masked_write: q=%b", bus.q);
  endtask

  task automatic test_lifo();
    apply(0, 1, 4'hF, 4'b0001, 0, 0, 0);
    apply(0, 1, 4'hF, 4'b0010, 1, 0, 0);
    apply(0, 1, 4'hF, 4'b0011, 1, 0, 0);
    vectors++; if (bus.depth !== CNT_W'(2) || bus.q !== 4'b0011) begin miscompares++; $display("FAIL lifo_push got depth=%0d q=%b exp depth=2 q=0011", bus.depth, bus.q); end
    apply(0, 0, 4'h0, 4'h0, 0, 1, 0);
    vectors++; if (bus.q !== 4'b0010) begin miscompares++; $display("FAIL lifo_pop1 got=%b exp=0010", bus.q); end
    apply(0, 0, 4'h0, 4'h0, 0, 1, 0);
    vectors++; if (bus.q !== 4'b0001 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL lifo_pop2 got q=%b empty=%b exp q=0001 empty=1", bus.q, bus.empty); end
    $display("lifo: q=%b depth=%0d", bus.q, bus.depth);
  endtask

  task automatic test_overflow();
    logic [FLAG_W-1:0] exp_q;
    apply(0, 1, 4'hF, 4'd1, 0, 0, 0);
    for (int i = 2; i <= 5; i++) apply(0, 1, 4'hF, FLAG_W'(i), 1, 0, 0);
    apply(0, 0, 4'h0, 4'h0, 1, 0, 0);
    vectors++; if (bus.depth !== CNT_W'(4) || bus.full !== 1'b1) begin miscompares++; $display("FAIL ovf_depth got depth=%0d full=%b exp 4/1", bus.depth, bus.full); end
    vectors++; if (bus.ovf_err !== 1'b1 || bus.q !== 4'd5) begin miscompares++; $display("FAIL ovf_flag got ovf=%b q=%0d exp 1/5", bus.ovf_err, bus.q); end
    for (int i = 4; i >= 1; i--) begin
      exp_q = FLAG_W'(i);
      apply(0, 0, 4'h0, 4'h0, 0, 1, 0);
      vectors++; if (bus.q !== exp_q) begin miscompares++; $display("FAIL ovf_pop got=%0d exp=%0d", bus.q, exp_q); end
    end
    apply(0, 0, 4'h0, 4'h0, 0, 0, 1);
    vectors++; if (bus.ovf_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got=%b exp=0", bus.ovf_err); end
    $display("overflow: q=%0d depth=%0d ovf=%b", bus.q, bus.depth, bus.ovf_err);
  endtask

  task automatic test_underflow_simul();
    apply(0, 1, 4'hF, 4'b0110, 0, 0, 0);
    apply(0, 0, 4'h0, 4'h0, 0, 1, 0);
    vectors++; if (bus.q !== 4'b0110 || bus.unf_err !== 1'b1 || bus.depth !== CNT_W'(0)) begin miscompares++; $display("FAIL unf got q=%b unf=%b depth=%0d exp 0110/1/0", bus.q, bus.unf_err, bus.depth); end
    apply(0, 0, 4'h0, 4'h0, 1, 0, 0);
    apply(0, 1, 4'hF, 4'b0001, 1, 0, 0);
    apply(0, 1, 4'b1000, 4'b1000, 1, 1, 0);
    vectors++; if (bus.q !== 4'b1001 || bus.depth !== CNT_W'(2)) begin miscompares++; $display("FAIL simul got q=%b depth=%0d exp 1001/2", bus.q, bus.depth); end
    vectors++; if (bus.ovf_err !== 1'b0) begin miscompares++; $display("FAIL simul_err got ovf=%b exp=0", bus.ovf_err); end
    $display("underflow_simul: q=%b depth=%0d unf=%b", bus.q, bus.depth, bus.unf_err);
  endtask

  task automatic test_reset_mid();
    apply(0, 0, 4'h0, 4'h0, 1, 0, 0);
    vectors++; if (bus.depth !== CNT_W'(3) || bus.unf_err !== 1'b1) begin miscompares++; $display("FAIL mid_pre got depth=%0d unf=%b exp 3/1", bus.depth, bus.unf_err); end
    apply(1, 0, 4'h0, 4'h0, 0, 1, 0);
    vectors++; if (bus.depth !== CNT_W'(0) || bus.q !== 4'b0000 || bus.unf_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst got depth=%0d q=%b unf=%b exp 0/0000/0", bus.depth, bus.q, bus.unf_err); end
    apply(0, 0, 4'h0, 4'h0, 0, 1, 1);
    vectors++; if (bus.unf_err !== 1'b1) begin miscompares++; $display("FAIL clr_vs_set got unf=%b exp=1", bus.unf_err); end
    $display("reset_mid: depth=%0d unf=%b", bus.depth, bus.unf_err);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      vectors++;
      if (bus.q !== m_q || bus.depth !== CNT_W'(m_stack.size()) ||
          bus.full !== (m_stack.size() == DEPTH) || bus.empty !== (m_stack.size() == 0) ||
          bus.ovf_err !== m_ovf || bus.unf_err !== m_unf) begin
        miscompares++;
        $display("FAIL random[%0d] got q=%b d=%0d f=%b e=%b o=%b u=%b exp q=%b d=%0d o=%b u=%b",
                 n, bus.q, bus.depth, bus.full, bus.empty, bus.ovf_err, bus.unf_err,
                 m_q, m_stack.size(), m_ovf, m_unf);
      end
    end
    $display("random: 400 cycles, final q=%b depth=%0d", bus.q, bus.depth);
  endtask

  initial begin
    rst = 1'b1;
    bus.flags_reg_write_enable = 1'b0;
    bus.flags_mask = '0;
    bus.d = '0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.err_clr = 1'b0;
    m_q = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    test_reset();
    test_masked_write();
    test_lifo();
    test_overflow();
    test_underflow_simul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
